// File: rtl/aq_gemac_gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, data, optional zero pad, CRC32 FCS and inter-frame gap.
// All outputs except tx_ready are registered; each state decides the byte shown in the next cycle.
//
// state  | meaning
// IDLE   | waiting for tx_valid, txe low
// PRE    | preamble 0x55 bytes going out
// SFD    | last preamble byte on the wire, SFD registered next
// DATA   | accepting upstream bytes, tx_ready high
// PAD    | zero bytes until the minimum data length
// FCS    | four inverted CRC bytes, LSB first
// IFG    | inter-frame gap, txe low
// ERR    | underrun byte with TX_ER on the wire
// DROP   | discard upstream bytes up to tx_last
module aq_gemac_gmii_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter bit PAD_EN    = 1'b1,
  parameter int MIN_DATA  = 60
) (
  input  logic       tx_clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] bgmii_txd,
  output logic       bgmii_txe,
  output logic       bgmii_txer,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_underrun
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_IFG, S_ERR, S_DROP
  } state_t;

  localparam logic [10:0] MIN_CNT = 11'(MIN_DATA);
  localparam logic [7:0]  IFG_CNT = 8'(IFG_BYTES);

  state_t      state;
  logic [31:0] crc;
  logic [10:0] byte_cnt;
  logic [7:0]  tmr;
  logic [10:0] byte_inc;
  logic [31:0] crc_next;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign tx_ready = (state == S_DATA) || (state == S_DROP);
  assign byte_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
  assign crc_next = crc_byte(crc, (state == S_PAD) ? 8'h00 : tx_data);

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      crc         <= 32'hFFFFFFFF;
      byte_cnt    <= '0;
      tmr         <= '0;
      bgmii_txd   <= '0;
      bgmii_txe   <= 1'b0;
      bgmii_txer  <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_done     <= 1'b0;
      tx_underrun <= 1'b0;
      bgmii_txer  <= 1'b0;
      case (state)
        S_IDLE: begin
          bgmii_txd <= 8'h00;
          bgmii_txe <= 1'b0;
          crc       <= 32'hFFFFFFFF;
          byte_cnt  <= '0;
          if (tx_valid) begin
            state     <= S_PRE;
            bgmii_txd <= 8'h55;
            bgmii_txe <= 1'b1;
            tx_busy   <= 1'b1;
            tmr       <= 8'd5;
          end
        end
        S_PRE: begin
          bgmii_txd <= 8'h55;
          if (tmr == 8'd0) state <= S_SFD;
          else tmr <= tmr - 8'd1;
        end
        S_SFD: begin
          bgmii_txd <= 8'hD5;
          state     <= S_DATA;
        end
        S_DATA: begin
          if (tx_valid) begin
            bgmii_txd <= tx_data;
            crc       <= crc_next;
            byte_cnt  <= byte_inc;
            if (tx_last) begin
              tmr   <= 8'd3;
              state <= (PAD_EN && (byte_inc < MIN_CNT)) ? S_PAD : S_FCS;
            end
          end else begin
            // upstream starved mid-frame: poison the frame instead of stretching it
            bgmii_txd   <= 8'h00;
            bgmii_txer  <= 1'b1;
            tx_underrun <= 1'b1;
            state       <= S_ERR;
          end
        end
        S_PAD: begin
          bgmii_txd <= 8'h00;
          crc       <= crc_next;
          byte_cnt  <= byte_inc;
          if (byte_inc >= MIN_CNT) begin
            tmr   <= 8'd3;
            state <= S_FCS;
          end
        end
        S_FCS: begin
          bgmii_txd <= ~crc[7:0];
          crc       <= crc >> 8;
          if (tmr == 8'd0) begin
            tx_done <= 1'b1;
            tmr     <= IFG_CNT;
            state   <= S_IFG;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_IFG: begin
          bgmii_txd <= 8'h00;
          bgmii_txe <= 1'b0;
          if (tmr == 8'd0) begin
            tx_busy <= 1'b0;
            state   <= S_IDLE;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end
        S_ERR: begin
          bgmii_txd <= 8'h00;
          bgmii_txe <= 1'b0;
          state     <= S_DROP;
        end
        S_DROP: begin
          bgmii_txd <= 8'h00;
          bgmii_txe <= 1'b0;
          if (tx_valid && tx_last) begin
            tmr   <= IFG_CNT;
            state <= S_IFG;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aq_gemac_gmii_tx_framer.sv
// Bench for the GMII TX framer: one unpadded and one padded instance, checked against
// a frame-level model (preamble, data, pad, bit-serial CRC32) kept in the bench.
module tb_aq_gemac_gmii_tx_framer;

  localparam int IFG = 12;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last, tx_sel;

  logic       rdy_np, txe_np, txer_np, busy_np, done_np, un_np;
  logic [7:0] txd_np;
  logic       rdy_p, txe_p, txer_p, busy_p, done_p, un_p;
  logic [7:0] txd_p;

  logic       rdy_m, txe_m, txer_m, busy_m, done_m, un_m;
  logic [7:0] txd_m;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  int cap_done_i, cap_done_n, cap_er_i, cap_er_n, cap_un_i, cap_un_n;
  int n_cmp = 0;
  int n_err = 0;
  int idle_bad = 0;

  always #5 clk = ~clk;

  aq_gemac_gmii_tx_framer #(.IFG_BYTES(IFG), .PAD_EN(1'b0), .MIN_DATA(60)) dut_np (
    .tx_clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid & ~tx_sel),
    .tx_last(tx_last), .tx_ready(rdy_np), .bgmii_txd(txd_np), .bgmii_txe(txe_np),
    .bgmii_txer(txer_np), .tx_busy(busy_np), .tx_done(done_np), .tx_underrun(un_np));

  aq_gemac_gmii_tx_framer #(.IFG_BYTES(IFG), .PAD_EN(1'b1), .MIN_DATA(60)) dut_p (
    .tx_clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid & tx_sel),
    .tx_last(tx_last), .tx_ready(rdy_p), .bgmii_txd(txd_p), .bgmii_txe(txe_p),
    .bgmii_txer(txer_p), .tx_busy(busy_p), .tx_done(done_p), .tx_underrun(un_p));

  assign rdy_m  = tx_sel ? rdy_p  : rdy_np;
  assign txe_m  = tx_sel ? txe_p  : txe_np;
  assign txer_m = tx_sel ? txer_p : txer_np;
  assign busy_m = tx_sel ? busy_p : busy_np;
  assign done_m = tx_sel ? done_p : done_np;
  assign un_m   = tx_sel ? un_p   : un_np;
  assign txd_m  = tx_sel ? txd_p  : txd_np;

  // txd must idle at zero and TX_ER only appears with TX_EN
  always @(negedge clk) begin
    if (!txe_np && (txd_np != 8'h00 || txer_np)) idle_bad++;
    if (!txe_p && (txd_p != 8'h00 || txer_p)) idle_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void build_exp(input bit pad);
    logic [7:0]  body[$];
    logic [31:0] c;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    body = tx_q;
    if (pad) while (body.size() < 60) body.push_back(8'h00);
    c = 32'hFFFFFFFF;
    foreach (body[i]) begin
      for (int b = 0; b < 8; b++) begin
        logic fb;
        fb = c[0] ^ body[i][b];
        c = {1'b0, c[31:1]};
        if (fb) c = c ^ 32'hEDB88320;
      end
      exp_q.push_back(body[i]);
    end
    c = ~c;
    exp_q.push_back(c[7:0]);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[23:16]);
    exp_q.push_back(c[31:24]);
  endfunction

  task automatic drive(input int gap_after);
    int  idx = 0;
    int  t = 0;
    bit  gapped = 0;
    bit  acc;
    tx_valid = 1'b1;
    tx_data  = tx_q[0];
    tx_last  = (tx_q.size() == 1);
    while (idx < tx_q.size() && t < 5000) begin
      @(negedge clk);
      acc = rdy_m && tx_valid;
      @(posedge clk);
      #1;
      t++;
      if (!tx_valid) begin
        tx_valid = 1'b1;
      end else if (acc) begin
        idx++;
        if (idx < tx_q.size()) begin
          tx_data = tx_q[idx];
          tx_last = (idx == tx_q.size() - 1);
        end else begin
          tx_valid = 1'b0;
          tx_last  = 1'b0;
        end
        if (idx == gap_after && !gapped) begin
          gapped   = 1;
          tx_valid = 1'b0;
        end
      end
    end
    chk("drive_timeout", t < 5000, 1);
  endtask

  task automatic capture(input int bound);
    int t = 0;
    cap_q.delete();
    cap_done_i = -1; cap_done_n = 0;
    cap_er_i = -1;   cap_er_n = 0;
    cap_un_i = -1;   cap_un_n = 0;
    while (!txe_m && t < bound) begin
      @(negedge clk);
      t++;
    end
    chk("capture_start_timeout", t < bound, 1);
    t = 0;
    while (txe_m && t < 3000) begin
      if (done_m) begin cap_done_n++; cap_done_i = cap_q.size(); end
      if (txer_m) begin cap_er_n++;   cap_er_i = cap_q.size();   end
      if (un_m)   begin cap_un_n++;   cap_un_i = cap_q.size();   end
      cap_q.push_back(txd_m);
      @(negedge clk);
      t++;
    end
  endtask

  task automatic compare_frame(input string tag, input bit pad);
    int n;
    build_exp(pad);
    chk({tag, "_len"}, cap_q.size(), exp_q.size());
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_byte%0d", tag, i), cap_q[i], exp_q[i]);
    chk({tag, "_done_n"}, cap_done_n, 1);
    chk({tag, "_done_pos"}, cap_done_i, exp_q.size() - 1);
    chk({tag, "_txer_n"}, cap_er_n, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((busy_m || txe_m) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", t < 200, 1);
  endtask

  task automatic load_ascii();
    tx_q.delete();
    for (int i = 0; i < 9; i++) tx_q.push_back(8'h31 + 8'(i));
  endtask

  task automatic load_rand(input int n);
    tx_q.delete();
    repeat (n) tx_q.push_back(8'($urandom));
  endtask

  initial begin
    int cnt;
    rst = 1'b1; tx_valid = 1'b0; tx_last = 1'b0; tx_data = 8'h00; tx_sel = 1'b0;
    #23;
    chk("rst_txe", txe_np, 0);
    chk("rst_txd", txd_np, 0);
    chk("rst_busy", busy_p, 0);
    chk("rst_ready", rdy_p, 0);
    #4 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", rdy_np, 0);

    // "123456789" without padding, known FCS CBF43926
    tx_sel = 1'b0;
    load_ascii();
    fork drive(-1); capture(50); join
    compare_frame("t1", 0);
    chk("t1_len21", cap_q.size(), 21);
    if (cap_q.size() == 21) begin
      chk("t1_fcs0", cap_q[17], 8'h26);
      chk("t1_fcs1", cap_q[18], 8'h39);
      chk("t1_fcs2", cap_q[19], 8'hF4);
      chk("t1_fcs3", cap_q[20], 8'hCB);
    end
    cnt = 0;
    while (busy_m && cnt < 100) begin @(negedge clk); cnt++; end
    chk("t1_busy_ifg", cnt, IFG);
    wait_idle();

    // single byte, padded to 60
    tx_sel = 1'b1;
    tx_q.delete(); tx_q.push_back(8'hAA);
    fork drive(-1); capture(50); join
    compare_frame("t2", 1);
    chk("t2_len72", cap_q.size(), 72);
    wait_idle();

    // exactly minimum length, no pad bytes
    load_rand(60);
    fork drive(-1); capture(50); join
    compare_frame("t3", 1);
    wait_idle();

    // back-to-back with tx_valid held high
    load_rand(5);
    fork
      begin drive(-1); drive(-1); end
      begin
        capture(50);
        compare_frame("t4a", 1);
        cnt = 0;
        while (!txe_m && cnt < 100) begin @(negedge clk); cnt++; end
        chk("t4_gap", cnt, IFG + 1);
        capture(50);
        compare_frame("t4b", 1);
      end
    join
    wait_idle();

    // underrun after 10 data bytes
    tx_sel = 1'b0;
    load_rand(20);
    fork drive(10); capture(50); join
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    for (int i = 0; i < 10; i++) exp_q.push_back(tx_q[i]);
    exp_q.push_back(8'h00);
    chk("t5_len", cap_q.size(), 19);
    for (int i = 0; i < 19 && i < cap_q.size(); i++)
      chk($sformatf("t5_byte%0d", i), cap_q[i], exp_q[i]);
    chk("t5_txer_n", cap_er_n, 1);
    chk("t5_txer_pos", cap_er_i, 18);
    chk("t5_un_n", cap_un_n, 1);
    chk("t5_un_pos", cap_un_i, 18);
    chk("t5_done_n", cap_done_n, 0);
    wait_idle();
    load_ascii();
    fork drive(-1); capture(50); join
    compare_frame("t5_next", 0);
    wait_idle();

    // random frames on both instances
    for (int k = 0; k < 6; k++) begin
      tx_sel = 1'($urandom_range(0, 1));
      load_rand($urandom_range(1, 70));
      fork drive(-1); capture(50); join
      compare_frame($sformatf("rnd%0d", k), tx_sel);
      wait_idle();
    end

    // asynchronous reset mid-DATA, then a clean frame
    tx_sel = 1'b0;
    tx_valid = 1'b1; tx_last = 1'b0; tx_data = 8'h5A;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("t6_txe", txe_np, 0);
    chk("t6_txd", txd_np, 0);
    chk("t6_busy", busy_np, 0);
    chk("t6_ready", rdy_np, 0);
    tx_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    load_ascii();
    fork drive(-1); capture(50); join
    compare_frame("t6_next", 0);
    wait_idle();

    chk("idle_txd_zero", idle_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
